// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Arbitrates the single register-file write port between the in-order W stage
// (fixed priority, no added latency) and the out-of-band long-latency unit.
// Long-latency results wait in a small FIFO and drain whenever the W stage is
// not writing. The block also exports a mask of queued destinations for the
// hazard unit, and raises a stall request if the FIFO head has waited too long.

module wb_port_arbiter #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_regwrite,
    input  logic [4:0]               pipe_rd,
    input  logic [XLEN-1:0]          pipe_result,
    input  logic                     lu_valid,
    output logic                     lu_ready,
    input  logic [4:0]               lu_rd,
    input  logic [XLEN-1:0]          lu_data,
    output logic                     rf_we,
    output logic [4:0]               rf_rd,
    output logic [XLEN-1:0]          rf_wd,
    output logic [31:0]              pend_rd_mask,
    output logic [$clog2(DEPTH):0]   pend_count,
    output logic                     stall_req
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    // FIFO storage: destination and data arrays carry no reset; only the
    // per-entry valid bits and the pointers/count are control state.
    logic [4:0]        r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]  r_vld;
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic              r_stall;

    logic              w_pipe_wr;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count_next;
    logic [WAIT_W-1:0] w_wait_next;
    logic [31:0]       w_mask;

    // Saturating increment for the head-wait counter.
    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        if (v >= WAIT_MAX) begin
            return WAIT_MAX;
        end
        return v + WAIT_W'(1);
    endfunction

    // A W-stage write to x0 is architecturally a no-op, so it leaves the port free.
    assign w_pipe_wr = pipe_regwrite && (pipe_rd != 5'd0);
    assign w_empty   = (r_count == '0);

    // Ready depends only on occupancy, never on this cycle's pop.
    assign lu_ready  = (r_count < CNT_FULL);

    // A handshake with rd=0 completes but nothing is stored.
    assign w_accept  = lu_valid && lu_ready;
    assign w_push    = w_accept && (lu_rd != 5'd0);

    // Write-port grant: W stage first, otherwise drain the FIFO head.
    always_comb begin
        rf_we = 1'b0;
        rf_rd = 5'd0;
        rf_wd = '0;
        w_pop = 1'b0;
        if (w_pipe_wr) begin
            rf_we = 1'b1;
            rf_rd = pipe_rd;
            rf_wd = pipe_result;
        end else if (!w_empty) begin
            rf_we = 1'b1;
            rf_rd = r_rd[r_rptr];
            rf_wd = r_data[r_rptr];
            w_pop = 1'b1;
        end
    end

    // Occupancy after this edge; a simultaneous push and pop cancel.
    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // Head-wait counter advances only while entries sit undrained.
    always_comb begin
        w_wait_next = '0;
        if (!w_empty && !w_pop) begin
            w_wait_next = sat_inc(r_wait);
        end
    end

    // Destinations of all valid entries; x0 can never be pending.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i]) begin
                w_mask[r_rd[i]] = 1'b1;
            end
        end
        w_mask[0] = 1'b0;
    end

    assign pend_rd_mask = w_mask;
    assign pend_count   = r_count;
    assign stall_req    = r_stall;

    // Store the payload of an accepted result at the tail slot.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_rd[r_wptr]   <= lu_rd;
            r_data[r_wptr] <= lu_data;
        end
    end

    // FIFO control: pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_vld[r_rptr] <= 1'b0;
                r_rptr        <= r_rptr + PTR_W'(1);
            end
            if (w_push) begin
                r_vld[r_wptr] <= 1'b1;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    // Starvation tracking: stall request is registered off the next wait value,
    // so it drops on the same edge that performs the first pop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait  <= '0;
            r_stall <= 1'b0;
        end else begin
            r_wait  <= w_wait_next;
            r_stall <= (w_wait_next >= WAIT_MAX);
        end
    end

endmodule
